// File: rtl/pipelined_ripple_subtractor.sv
// Pipelined SIZE-bit ripple-borrow subtractor: d = a - b - bin, with borrow-out.
// One register stage per CHUNK-bit slice; borrow ripples stage to stage.
// Ports: clk, rst (sync, active-high), in_valid/in_ready, a, b, bin,
//        out_valid/out_ready, d, bout, ovf (only with OVERFLOW_FLAG_EN).
// Optional feature macro: OVERFLOW_FLAG_EN (adds registered signed-overflow ovf).
// Requires SIZE to be a multiple of CHUNK and SIZE/CHUNK >= 2.
module pipelined_ripple_subtractor #(
    parameter int SIZE  = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] d,
    output logic            bout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic            ovf
`endif
);

    localparam int STAGES = SIZE / CHUNK;

    // Returns {borrow_out, difference} for one slice, bit-serial.
    function automatic logic [CHUNK:0] sub_slice(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             br_in
    );
        logic [CHUNK-1:0] dd;
        logic             br;
        br = br_in;
        for (int i = 0; i < CHUNK; i++) begin
            dd[i] = x[i] ^ y[i] ^ br;
            br    = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        return {br, dd};
    endfunction

    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // Stages 0..STAGES-2. w_q holds finished low slices plus untouched a
    // slices above; b_q holds only the b slices not yet consumed, right
    // aligned so the next stage always reads its slice at bit 0.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_stg
        localparam int PBW = SIZE - k * CHUNK;
        localparam int BW  = PBW - CHUNK;

        logic            pv;
        logic [SIZE-1:0] pw;
        logic [PBW-1:0]  pb;
        logic            pbr;

        logic            v_d, v_q;
        logic [SIZE-1:0] w_d, w_q;
        logic [BW-1:0]   b_d, b_q;
        logic            br_d, br_q;

        if (k == 0) begin : g_in
            assign pv  = in_valid;
            assign pw  = a;
            assign pb  = b;
            assign pbr = bin;
        end else begin : g_prev
            assign pv  = g_stg[k-1].v_q;
            assign pw  = g_stg[k-1].w_q;
            assign pb  = g_stg[k-1].b_q;
            assign pbr = g_stg[k-1].br_q;
        end

        always_comb begin
            logic [CHUNK:0] r;
            r    = sub_slice(pw[k*CHUNK +: CHUNK], pb[CHUNK-1:0], pbr);
            v_d  = v_q;
            w_d  = w_q;
            b_d  = b_q;
            br_d = br_q;
            if (adv) begin
                v_d                  = pv;
                w_d                  = pw;
                w_d[k*CHUNK +: CHUNK] = r[CHUNK-1:0];
                b_d                  = pb[PBW-1:CHUNK];
                br_d                 = r[CHUNK];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q  <= 1'b0;
                w_q  <= '0;
                b_q  <= '0;
                br_q <= 1'b0;
            end else begin
                v_q  <= v_d;
                w_q  <= w_d;
                b_q  <= b_d;
                br_q <= br_d;
            end
        end
    end

    // Final stage resolves the top slice and forms the output register.
    localparam int LK = STAGES - 1;

    logic             lv;
    logic [SIZE-1:0]  lw;
    logic [CHUNK-1:0] lb;
    logic             lbr;

    assign lv  = g_stg[LK-1].v_q;
    assign lw  = g_stg[LK-1].w_q;
    assign lb  = g_stg[LK-1].b_q;
    assign lbr = g_stg[LK-1].br_q;

    logic            out_v_d, out_v_q;
    logic [SIZE-1:0] d_d, d_q;
    logic            bout_d, bout_q;
`ifdef OVERFLOW_FLAG_EN
    logic            ovf_d, ovf_q;
`endif

    always_comb begin
        logic [CHUNK:0] r;
        r       = sub_slice(lw[LK*CHUNK +: CHUNK], lb, lbr);
        out_v_d = out_v_q;
        d_d     = d_q;
        bout_d  = bout_q;
`ifdef OVERFLOW_FLAG_EN
        ovf_d   = ovf_q;
`endif
        if (adv) begin
            out_v_d                = lv;
            d_d                    = lw;
            d_d[LK*CHUNK +: CHUNK] = r[CHUNK-1:0];
            bout_d                 = r[CHUNK];
`ifdef OVERFLOW_FLAG_EN
            // lw[SIZE-1] is still the original a sign bit here.
            ovf_d = (lw[SIZE-1] ^ lb[CHUNK-1]) & (lw[SIZE-1] ^ r[CHUNK-1]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            out_v_q <= out_v_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign out_valid = out_v_q;
    assign d         = d_q;
    assign bout      = bout_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_ripple_subtractor.sv
// Scoreboard bench for pipelined_ripple_subtractor (SIZE=16, CHUNK=4).
// Driver pushes expected results; a monitor pops and compares on handshake.
module tb_pipelined_ripple_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d;
    logic        bout;
`ifdef OVERFLOW_FLAG_EN
    logic        ovf;
`endif

    pipelined_ripple_subtractor #(.SIZE(16), .CHUNK(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d        (d),
        .bout     (bout)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        logic        bout;
        logic        ovf;
        int          acc;
        bit          lat;
        bit          grp;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int gcount = 0;
    int gfirst = -1;
    int glast = -1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] ta, input logic [15:0] tbv,
                        input logic tbin, input logic [15:0] ed,
                        input logic eb, input bit lat, input bit grp);
        exp_t e;
        int n;
        @(negedge clk);
        a        = ta;
        b        = tbv;
        bin      = tbin;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.d    = ed;
            e.bout = eb;
            e.ovf  = (ta[15] ^ tbv[15]) & (ta[15] ^ ed[15]);
            e.acc  = cyc;
            e.lat  = lat;
            e.grp  = grp;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
    endtask

    function automatic logic [16:0] ref_sub(input logic [15:0] x,
                                            input logic [15:0] y,
                                            input logic c);
        return {1'b0, x} - {1'b0, y} - {16'd0, c};
    endfunction

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst && out_valid && !out_ready)
            check("in_ready_stall", {31'd0, in_ready}, 32'd0);
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", {16'd0, d}, 32'hDEAD);
            end else begin
                e = q.pop_front();
                check("d", {16'd0, d}, {16'd0, e.d});
                check("bout", {31'd0, bout}, {31'd0, e.bout});
`ifdef OVERFLOW_FLAG_EN
                check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
                if (e.lat) check("latency", cyc - e.acc, 32'd4);
                if (e.grp) begin
                    if (gfirst < 0) gfirst = cyc;
                    glast = cyc;
                    gcount++;
                end
            end
        end
    end

    logic [15:0] sa[8] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h8000,
                           16'h7FFF, 16'hA5A5, 16'h0F0F, 16'h4321};
    logic [15:0] sb[8] = '{16'h4321, 16'h0000, 16'h0001, 16'h0001,
                           16'hFFFF, 16'h5A5A, 16'h0F0F, 16'h1234};
    logic        sc[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_d", {16'd0, d}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        send(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1, 0);
        send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1, 0);
        send(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1, 0);
        send(16'h0003, 16'h0003, 1'b1, 16'hFFFF, 1'b1, 1, 0);
`ifdef OVERFLOW_FLAG_EN
        send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1, 0);
        send(16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1, 0);
`endif
        idle();
        drain();

        fork
            begin
                logic [16:0] r;
                for (int i = 0; i < 8; i++) begin
                    r = ref_sub(sa[i], sb[i], sc[i]);
                    send(sa[i], sb[i], sc[i], r[15:0], r[16], 0, 1);
                end
                idle();
            end
            begin
                int n;
                n = 0;
                while (gcount < 1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", gcount, 32'd8);
        check("stream_span", glast - gfirst, 32'd10);

        send(16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 0, 0);
        send(16'h2222, 16'h0002, 1'b0, 16'h2220, 1'b0, 0, 0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
